// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES constants, the 4-word key type and the round-constant lookup.
//   Used by the forward key expansion and the inverse key schedule.
//   Contents:
//     AES_KEY_LEN / AES_NR / AES_WORD : AES-128 sizing
//     aes_key_t                       : 128-bit key as four 32-bit words,
//                                       word [3] = w0 (most significant word)
//     rcon(idx)                       : round constant byte for rounds 1..10
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_KEY_LEN = 128;
   localparam int AES_NR      = 10;
   localparam int AES_WORD    = 32;

   // Packed so that bits [127:96] (word index 3) hold w0, matching the
   // FIPS-197 hex string order of a flat 128-bit vector.
   typedef logic [3:0][AES_WORD-1:0] aes_key_t;

   // Round constant byte. Index 0 and anything above 10 give 0, so the
   // round-0 slot never contributes to the XOR network.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] rc;
      case (idx)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// ---------------------------------------------------------------------------
// aes_sbox_word
//   Combinational forward SubWord: applies the AES S-box to each of the four
//   bytes of a 32-bit word.
//   Ports:
//     word    in  32  word to substitute, byte order preserved
//     subbed  out 32  S-box of each byte of word
// ---------------------------------------------------------------------------
module aes_sbox_word (
   input  logic [31:0] word,
   output logic [31:0] subbed
);

   // Ascending outer range: the first byte of the literal is SBOX[0].
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign subbed = {SBOX[word[31:24]], SBOX[word[23:16]],
                    SBOX[word[15:8]],  SBOX[word[7:0]]};

endmodule

// File: rtl/aes_key_expansion_inv.sv
// ---------------------------------------------------------------------------
// aes_key_expansion_inv
//   Inverse AES-128 key schedule. Accepts the final round key and replays
//   every round key in descending order (NR, NR-1, ..., 0), one per output
//   handshake, for an on-the-fly decryption datapath.
//   Ports:
//     clk        in   1        clock, rising edge
//     reset      in   1        synchronous reset, active-low
//     Last_key   in   KEY_LEN  final round key, [127:96] = w0
//     valid_in   in   1        Last_key is valid
//     in_ready   out  1        idle, a job can be accepted
//     round_key  out  KEY_LEN  current round key, same order as Last_key
//     round_idx  out  4        round number of round_key
//     out_valid  out  1        round_key / round_idx valid
//     out_last   out  1        round-0 beat (original cipher key)
//     out_ready  in   1        downstream accepts the beat
//
//   Handshakes: an input job transfers on an edge where valid_in && in_ready;
//   an output beat transfers on an edge where out_valid && out_ready. Once
//   raised, out_valid and the beat contents stay stable until that beat
//   transfers. in_ready and out_valid are mutually exclusive (in_ready is
//   the IDLE state, out_valid the RUN state), so state is visible directly
//   on these two outputs.
// ---------------------------------------------------------------------------
module aes_key_expansion_inv
   import aes_pkg::*;
#(
   parameter int KEY_LEN       = AES_KEY_LEN,
   parameter int NUMS_OF_ROUND = AES_NR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [KEY_LEN-1:0] Last_key,
   input  logic               valid_in,
   output logic               in_ready,
   output logic [KEY_LEN-1:0] round_key,
   output logic [3:0]         round_idx,
   output logic               out_valid,
   output logic               out_last,
   input  logic               out_ready
);

   if (KEY_LEN != 128) begin : g_key_len_check
      $error("aes_key_expansion_inv: only KEY_LEN=128 is supported");
   end
   if (NUMS_OF_ROUND < 1 || NUMS_OF_ROUND > 15) begin : g_nr_check
      $error("aes_key_expansion_inv: NUMS_OF_ROUND must fit round_idx (1..15)");
   end

   localparam logic [3:0] NR_IDX = 4'(NUMS_OF_ROUND);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]          state;
   aes_key_t            cur;
   aes_key_t            prev_key;
   logic [AES_WORD-1:0] k0, k1, k2, k3;
   logic [AES_WORD-1:0] p3;
   logic [AES_WORD-1:0] rot_word;
   logic [AES_WORD-1:0] sub_word;
   logic                beat_done;

   // k0 is w0 (most significant word) of the current round key.
   assign {k0, k1, k2, k3} = cur;

   // Undo one forward expansion step. p3 is the previous round's last word,
   // which is exactly what the forward step fed through RotWord/SubWord.
   assign p3       = k3 ^ k2;
   assign rot_word = {p3[23:0], p3[31:24]};

   aes_sbox_word u_sbox (
      .word   (rot_word),
      .subbed (sub_word)
   );

   // rcon() is indexed by the round of cur: round r was built with Rcon[r].
   assign prev_key = {k0 ^ sub_word ^ {rcon(round_idx), 24'h0},
                      k1 ^ k0,
                      k2 ^ k1,
                      p3};

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == RUN);
   assign out_last  = out_valid && (round_idx == 4'd0);
   assign round_key = cur;
   assign beat_done = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cur       <= '0;
         round_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_in) begin
                  cur       <= Last_key;
                  round_idx <= NR_IDX;
                  state     <= RUN;
               end
            end
            RUN: begin
               // valid_in is ignored here; the job on the wire is dropped.
               if (beat_done) begin
                  if (round_idx == 4'd0) begin
                     // Return to IDLE only; a new job needs a further edge.
                     state <= IDLE;
                  end else begin
                     cur       <= prev_key;
                     round_idx <= round_idx - 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expansion_inv.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expansion_inv
//   Bench for the inverse AES-128 key schedule. Expected beats come from an
//   independent forward key expansion (S-box derived from GF(2^8) inversion
//   plus the affine map), pushed to exp_q when a job is driven and popped by
//   the output monitor on every handshake.
// ---------------------------------------------------------------------------
module tb_aes_key_expansion_inv;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] last_key;
   logic         valid_in;
   logic         in_ready;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         out_valid;
   logic         out_last;
   logic         out_ready;

   int           vectors     = 0;
   int           miscompares = 0;
   int           beats       = 0;
   bit           rnd_ready   = 1'b0;
   logic [132:0] exp_q[$];
   logic [127:0] rk [0:10];

   always #5 clk = ~clk;

   aes_key_expansion_inv dut (
      .clk       (clk),
      .reset     (reset),
      .Last_key  (last_key),
      .valid_in  (valid_in),
      .in_ready  (in_ready),
      .round_key (round_key),
      .round_idx (round_idx),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   // ---------------- reference model: forward AES-128 key expansion -------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox_m(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word_m(input logic [31:0] w);
      return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
   endfunction

   task automatic expand(input logic [127:0] master);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      w[0] = master[127:96];
      w[1] = master[95:64];
      w[2] = master[63:32];
      w[3] = master[31:0];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- output monitor / scoreboard ---------------------------
   task automatic monitor();
      logic [132:0] e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            beats++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL beat_unexpected: got idx=%0d key=%h, required no beat",
                        round_idx, round_key);
            end else begin
               e = exp_q.pop_front();
               if ({round_key, round_idx, out_last} !== e) begin
                  miscompares++;
                  $display("FAIL beat_check: got key=%h idx=%0d last=%b, required key=%h idx=%0d last=%b",
                           round_key, round_idx, out_last, e[132:5], e[4:1], e[0]);
               end
            end
         end
      end
   endtask

   // ---------------- drivers ----------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Drives one job whose Last_key is the round-10 key of master.
   task automatic start_job(input logic [127:0] master);
      int n = 0;
      expand(master);
      while (in_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end
      last_key = rk[10];
      valid_in = 1'b1;
      for (int r = 10; r >= 0; r--) exp_q.push_back({rk[r], 4'(r), (r == 0)});
      tick();
      valid_in = 1'b0;
   endtask

   task automatic wait_idx(input logic [3:0] idx);
      int n = 0;
      while (!(out_valid === 1'b1 && round_idx === idx) && n < 100) begin
         tick();
         n++;
      end
      vectors++;
      if (n >= 100) begin
         miscompares++;
         $display("FAIL wait_idx_timeout: idx=%0d valid=%b, required idx=%0d", round_idx, out_valid, idx);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid !== 1'b0) && n < 400) begin
         tick();
         n++;
      end
      vectors++;
      if (n >= 400) begin
         miscompares++;
         $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      end
      rnd_ready = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic check_beats(input int required);
      vectors++;
      if (beats !== required) begin
         miscompares++;
         $display("FAIL beat_count: got %0d, required %0d", beats, required);
      end
   endtask

   // ---------------- scenarios --------------------------------------------
   task automatic test_reset();
      reset     = 1'b0;
      valid_in  = 1'b1;
      last_key  = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b1;
      tick();
      tick();
      vectors++;
      if ({out_valid, out_last, round_idx, round_key} !== 134'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%b last=%b idx=%0d key=%h, required all 0",
                  out_valid, out_last, round_idx, round_key);
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      reset    = 1'b1;
      valid_in = 1'b0;
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_beat: got out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_fips();
      beats = 0;
      start_job(128'h2b7e151628aed2a6abf7158809cf4f3c);
      for (int c = 0; c <= 10; c++) begin
         vectors++;
         if (out_valid !== 1'b1 || round_idx !== 4'(10 - c)) begin
            miscompares++;
            $display("FAIL fips_seq: cycle %0d got valid=%b idx=%0d, required valid=1 idx=%0d",
                     c, out_valid, round_idx, 10 - c);
         end
         if (c == 0 || c == 1 || c == 9 || c == 10) begin
            logic [127:0] req;
            case (c)
               0:       req = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
               1:       req = 128'hac7766f319fadc2128d12941575c006e;
               9:       req = 128'ha0fafe1788542cb123a339392a6c7605;
               default: req = 128'h2b7e151628aed2a6abf7158809cf4f3c;
            endcase
            vectors++;
            if (round_key !== req || out_last !== (c == 10)) begin
               miscompares++;
               $display("FAIL fips_key: cycle %0d got key=%h last=%b, required key=%h last=%b",
                        c, round_key, out_last, req, (c == 10));
            end
         end
         tick();
      end
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL fips_end: got valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
      drain();
      check_beats(11);
   endtask

   task automatic test_loopback();
      beats = 0;
      start_job(128'h00112233445566778899aabbccddeeff);
      drain();
      check_beats(11);
   endtask

   task automatic test_backpressure();
      logic [127:0] held;
      beats = 0;
      start_job({$urandom, $urandom, $urandom, $urandom});
      wait_idx(4'd5);
      out_ready = 1'b0;
      held      = round_key;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (round_key !== held || round_idx !== 4'd5 || out_valid !== 1'b1 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: got key=%h idx=%0d valid=%b last=%b, required key=%h idx=5 valid=1 last=0",
                     round_key, round_idx, out_valid, out_last, held);
         end
      end
      out_ready = 1'b1;
      tick();
      vectors++;
      if (round_idx !== 4'd4 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_release: got idx=%0d valid=%b, required idx=4 valid=1", round_idx, out_valid);
      end
      drain();
      check_beats(11);
   endtask

   task automatic test_busy();
      int n = 0;
      beats = 0;
      start_job({$urandom, $urandom, $urandom, $urandom});
      wait_idx(4'd7);
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_in_ready: got %b, required 0", in_ready);
      end
      last_key = {$urandom, $urandom, $urandom, $urandom};
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      wait_idx(4'd3);
      expand({$urandom, $urandom, $urandom, $urandom});
      last_key = rk[10];
      valid_in = 1'b1;
      for (int r = 10; r >= 0; r--) exp_q.push_back({rk[r], 4'(r), (r == 0)});
      while (out_valid !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      vectors++;
      if (in_ready !== 1'b1 || exp_q.size() != 11) begin
         miscompares++;
         $display("FAIL busy_first_done: got in_ready=%b outstanding=%0d, required 1/11", in_ready, exp_q.size());
      end
      tick();
      valid_in = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== rk[10]) begin
         miscompares++;
         $display("FAIL busy_held_accept: got valid=%b idx=%0d key=%h, required 1/10/%h",
                  out_valid, round_idx, round_key, rk[10]);
      end
      drain();
      check_beats(22);
   endtask

   task automatic test_reset_mid();
      beats = 0;
      start_job({$urandom, $urandom, $urandom, $urandom});
      wait_idx(4'd6);
      reset = 1'b0;
      tick();
      vectors++;
      if (out_valid !== 1'b0 || round_key !== 128'd0 || round_idx !== 4'd0 ||
          out_last !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid: got valid=%b key=%h idx=%0d last=%b in_ready=%b, required 0/0/0/0/1",
                  out_valid, round_key, round_idx, out_last, in_ready);
      end
      exp_q.delete();
      reset = 1'b1;
      beats = 0;
      start_job({$urandom, $urandom, $urandom, $urandom});
      drain();
      check_beats(11);
   endtask

   task automatic test_back_to_back();
      beats     = 0;
      rnd_ready = 1'b1;
      for (int j = 0; j < 4; j++) start_job({$urandom, $urandom, $urandom, $urandom});
      drain();
      check_beats(44);
   endtask

   initial begin
      reset     = 1'b0;
      valid_in  = 1'b0;
      last_key  = '0;
      out_ready = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_fips();
      test_loopback();
      test_backpressure();
      test_busy();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
